// File: rtl/minkowski_net_div_pkg.sv
// Shared types and constants for the Minkowski pipeline sequential signed divider.
// Holds the FSM state enum, default operand widths and divide-by-zero saturation values.
package minkowski_net_div_pkg;

   localparam int DIVIDEND_W_DEF = 13;
   localparam int DIVISOR_W_DEF  = 11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2,
      DONE = 2'd3
   } div_state_e;

   // Saturation patterns for a w-bit quotient: largest positive and most negative values.
   function automatic int Q_POS_MAX(input int w);
      return (1 << (w - 1)) - 1;
   endfunction

   function automatic int Q_NEG_MIN(input int w);
      return 1 << (w - 1);
   endfunction

endpackage

// File: rtl/minkowski_net_div_step.sv
// One radix-2 restoring division step: shift in the next dividend bit, then
// compare against the divisor and subtract when it fits.
module minkowski_net_div_step #(
   parameter int VW = 11
) (
   input  logic [VW-1:0] rem,
   input  logic          next_bit,
   input  logic [VW-1:0] divisor,
   output logic [VW:0]   rem_next,
   output logic          q_bit
);

   // rem is always below the divisor, so VW bits carry it; the shifted value needs VW+1.
   logic [VW:0] shifted;
   logic [VW:0] diff;

   assign shifted  = {rem, next_bit};
   assign diff     = shifted - {1'b0, divisor};
   assign q_bit    = (shifted >= {1'b0, divisor});
   assign rem_next = q_bit ? diff : shifted;

endmodule

// File: rtl/blk_bf5cc2.sv
// Sequential signed-by-unsigned restoring divider with valid/ready on both sides.
// Optional macro SDIV_ZERO_FLAG_EN adds the div_zero output flag.
//
// state | meaning
// IDLE  | waiting for an operand pair, in_ready high
// CALC  | one quotient bit per cycle, DW cycles
// FIX   | apply dividend sign or divide-by-zero saturation, register outputs
// DONE  | result held with out_valid until out_ready
module blk_bf5cc2
   import minkowski_net_div_pkg::*;
#(
   parameter int DIVIDEND_WIDTH = DIVIDEND_W_DEF,
   parameter int DIVISOR_WIDTH  = DIVISOR_W_DEF
) (
   input  logic                             ap_clk,
   input  logic                             ap_rst,
   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic signed [DIVIDEND_WIDTH-1:0] dividend,
   input  logic        [DIVISOR_WIDTH-1:0]  divisor,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic signed [DIVIDEND_WIDTH-1:0] quotient,
   output logic signed [DIVISOR_WIDTH:0]    remainder
`ifdef SDIV_ZERO_FLAG_EN
  ,output logic                             div_zero
`endif
);

   localparam int DW    = DIVIDEND_WIDTH;
   localparam int VW    = DIVISOR_WIDTH;
   localparam int CNT_W = (DW > 1) ? $clog2(DW) : 1;

   localparam logic [DW-1:0] QMAX = DW'(Q_POS_MAX(DW));
   localparam logic [DW-1:0] QMIN = DW'(Q_NEG_MIN(DW));

   div_state_e state, state_nxt;

   logic [CNT_W-1:0] cnt;
   logic [DW-1:0]    q_reg;
   logic [VW:0]      rem_reg;
   logic [VW-1:0]    div_reg;
   logic             neg;
   logic [DW-1:0]    mag;
   logic [VW:0]      rem_step;
   logic             q_bit;
   logic             dzero;

`ifdef SDIV_ZERO_FLAG_EN
   logic dz_reg;
   assign div_zero = dz_reg;
`endif

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign mag       = dividend[DW-1] ? -dividend : dividend;
   assign dzero     = (div_reg == '0);

   minkowski_net_div_step #(.VW(VW)) u_step (
      .rem      (rem_reg[VW-1:0]),
      .next_bit (q_reg[DW-1]),
      .divisor  (div_reg),
      .rem_next (rem_step),
      .q_bit    (q_bit)
   );

   always_ff @(posedge ap_clk) begin
      if (ap_rst) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (in_valid)  state_nxt = CALC;
         CALC: if (cnt == '0) state_nxt = FIX;
         FIX:                 state_nxt = DONE;
         DONE: if (out_ready) state_nxt = IDLE;
         default:             state_nxt = IDLE;
      endcase
   end

   // The dividend magnitude register doubles as the quotient shift register.
   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         cnt       <= '0;
         q_reg     <= '0;
         rem_reg   <= '0;
         div_reg   <= '0;
         neg       <= 1'b0;
         quotient  <= '0;
         remainder <= '0;
`ifdef SDIV_ZERO_FLAG_EN
         dz_reg    <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  q_reg   <= mag;
                  neg     <= dividend[DW-1];
                  div_reg <= divisor;
                  rem_reg <= '0;
                  cnt     <= CNT_W'(DW - 1);
               end
            end
            CALC: begin
               q_reg   <= {q_reg[DW-2:0], q_bit};
               rem_reg <= rem_step;
               if (cnt != '0) cnt <= cnt - 1'b1;
            end
            FIX: begin
               if (dzero) begin
                  quotient  <= neg ? QMIN : QMAX;
                  remainder <= '0;
               end else begin
                  quotient  <= neg ? -q_reg : q_reg;
                  remainder <= neg ? -rem_reg : rem_reg;
               end
`ifdef SDIV_ZERO_FLAG_EN
               dz_reg <= dzero;
`endif
            end
            default: ;
         endcase
      end
   end

endmodule
